apb_slave_regfile: RTL
======================

Name: apb_slave_regfile

Overview:
- APB responder (completer) at the slave end of the APB bus, below the address decoder.
- Receives one decoded select plus the common PENABLE/PWRITE/PADDR/PWDATA signals.
- Returns PRDATA/PREADY to the decoder, which muxes them back to the master.
- Holds a word-addressed register bank with a fixed, parameterised number of wait states per transfer.

Parameters:
- DATA_WIDTH, 32, width of PWDATA/PRDATA and of each register.
- ADDR_WIDTH, 32, width of PADDR.
- REG_NUM, 16, number of registers (power of two, ≥2); byte address range 0 .. REG_NUM*4-1.
- WAIT_CYCLES, 1, wait states inserted per transfer (0..15).

Ports:
- PCLK  in  1  system clock; all logic on rising edge.
- PRESET  in  1  synchronous, active-high reset.
- PSEL  in  1  slave select from decoder.
- PENABLE  in  1  APB access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PRDATA  out  DATA_WIDTH  read data, registered.
- PREADY  out  1  transfer-complete, registered.

Behaviour:
- Reset (PRESET=1 at a PCLK edge):
  - All registers, PRDATA and PREADY go to 0; wait counter goes to 0; FSM goes to IDLE.
  - Reset has priority over any bus activity, including a transfer in progress. An aborted transfer performs no write.
- Address decode:
  - Valid when PADDR[1:0]==0 and PADDR < REG_NUM*4.
  - Register index = PADDR[log2(REG_NUM)+1:2].
- FSM states: IDLE, WAIT, READY.
- IDLE:
  - Setup phase is PSEL=1, PENABLE=0.
  - On setup with WAIT_CYCLES==0: next state READY, PREADY<=1.
  - On setup with WAIT_CYCLES>0: next state WAIT, counter<=WAIT_CYCLES, PREADY<=0.
  - Otherwise stay in IDLE with PREADY=0.
- WAIT:
  - While PSEL=1 and PENABLE=1, counter decrements each cycle.
  - When counter==1: next state READY, PREADY<=1.
  - If PSEL falls (protocol abort): go to IDLE, PREADY<=0, no register update.
- READY (PREADY=1, transfer completes this cycle):
  - Write with valid address: register[index]<=PWDATA at this edge.
  - Write with invalid address: ignored.
  - Next state IDLE, PREADY<=0, PRDATA<=0.
- Resulting timing: access phase lasts exactly WAIT_CYCLES+1 cycles, with PREADY high only in the last one.
- Read data:
  - PRDATA is loaded with register[index] on the same edge that sets PREADY<=1, or 0 if the address is invalid.
  - PRDATA is 0 whenever PREADY=0 or a write is in progress.
- Back-to-back transfers: after READY the FSM is in IDLE, so the next setup is accepted immediately. This gives zero idle cycles between transfers, one transfer per WAIT_CYCLES+2 cycles.
- Inputs are sampled only in the states listed above. PADDR/PWRITE are sampled at setup and held internally; mid-transfer changes are ignored. PWDATA is sampled at the READY edge.
- Read-then-write to the same register in consecutive transfers: the read returns the old value and the write takes effect at the write's READY edge.

Optional Feature:
- Macro: APB_SLAVE_PSLVERR_EN.
- Defined:
  - Adds output port PSLVERR (1 bit, registered, reset 0).
  - PSLVERR is set together with PREADY when the held address is invalid (misaligned or out of range) and cleared with PREADY.
  - An erroring write does not modify any register; an erroring read returns PRDATA=0.
- Undefined:
  - No PSLVERR port.
  - Invalid accesses complete normally with PREADY, writes are dropped, reads return 0.

Test Plan:
- Reset then read all: PRESET=1 for 2 cycles, then read each address 0x00..0x3C → PRDATA=0 each time, PREADY high exactly 1 cycle per transfer, 2 access cycles each (WAIT_CYCLES=1).
- Write/read: write 0xDEADBEEF to 0x08, then read 0x08 → PRDATA=0xDEADBEEF; neighbouring registers 0x04 and 0x0C still read 0.
- Wait-state count: WAIT_CYCLES=3, read 0x10 → PREADY low for 3 access cycles, high on the 4th; with WAIT_CYCLES=0 → PREADY high on the first access cycle.
- Back-to-back: write 0x11111111 to 0x00, next cycle setup read 0x00, next setup write 0x22222222 to 0x00, then read → reads return 0x11111111 then 0x22222222, no idle cycles required.
- Invalid address: write 0xA5A5A5A5 to 0x40 and to 0x06 → no register changes (full readback sweep); with APB_SLAVE_PSLVERR_EN, PSLVERR=1 in the PREADY cycle of both transfers and 0 for valid ones.
- Abort/reset mid-transfer: setup write 0x12345678 to 0x04 with WAIT_CYCLES=2, drop PSEL after 1 access cycle → FSM to IDLE, 0x04 unchanged. Repeat with PRESET=1 during WAIT → PREADY=0 next cycle, all registers 0.

Source files
------------

// File: rtl/apb_slave_regfile.sv
// ============================================================================
// Module   : apb_slave_regfile
// Brief    : APB completer with a word-addressed register bank and a fixed
//            number of wait states per transfer.
//            Optional PSLVERR output enabled by APB_SLAVE_PSLVERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_slave_regfile #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int REG_NUM     = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
`ifdef APB_SLAVE_PSLVERR_EN
    output logic                  PSLVERR,
`endif
    output logic                  PREADY
);

    localparam int IDX_W = $clog2(REG_NUM);
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] C_WAIT = CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t                state_q,  state_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic [IDX_W-1:0]      idx_q,    idx_d;
    logic                  valid_q,  valid_d;
    logic                  write_q,  write_d;
    logic                  pready_q, pready_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [DATA_WIDTH-1:0] regs_q [REG_NUM];
    logic [DATA_WIDTH-1:0] regs_d [REG_NUM];
`ifdef APB_SLAVE_PSLVERR_EN
    logic                  pslverr_q, pslverr_d;
`endif

    logic                  setup_valid;
    logic [IDX_W-1:0]      setup_idx;

    // Aligned and no address bits set above the register window.
    assign setup_valid = (PADDR[1:0] == 2'b00) && (PADDR[ADDR_WIDTH-1:IDX_W+2] == '0);
    assign setup_idx   = PADDR[IDX_W+1:2];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        write_d   = write_q;
        pready_d  = 1'b0;
        prdata_d  = '0;
        regs_d    = regs_q;
`ifdef APB_SLAVE_PSLVERR_EN
        pslverr_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (PSEL && !PENABLE) begin
                    idx_d   = setup_idx;
                    valid_d = setup_valid;
                    write_d = PWRITE;
                    if (WAIT_CYCLES == 0) begin
                        state_d  = S_READY;
                        pready_d = 1'b1;
                        prdata_d = (!PWRITE && setup_valid) ? regs_q[setup_idx] : '0;
`ifdef APB_SLAVE_PSLVERR_EN
                        pslverr_d = !setup_valid;
`endif
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = C_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!PSEL) begin
                    // Master abandoned the transfer: nothing is written.
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (PENABLE) begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d  = S_READY;
                        cnt_d    = '0;
                        pready_d = 1'b1;
                        prdata_d = (!write_q && valid_q) ? regs_q[idx_q] : '0;
`ifdef APB_SLAVE_PSLVERR_EN
                        pslverr_d = !valid_q;
`endif
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            S_READY: begin
                state_d = S_IDLE;
                if (write_q && valid_q) begin
                    regs_d[idx_q] = PWDATA;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            write_q   <= 1'b0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
`ifdef APB_SLAVE_PSLVERR_EN
            pslverr_q <= 1'b0;
`endif
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            write_q   <= write_d;
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
`ifdef APB_SLAVE_PSLVERR_EN
            pslverr_q <= pslverr_d;
`endif
            regs_q    <= regs_d;
        end
    end

    assign PREADY  = pready_q;
    assign PRDATA  = prdata_q;
`ifdef APB_SLAVE_PSLVERR_EN
    assign PSLVERR = pslverr_q;
`endif

endmodule

`default_nettype wire
